// File: rtl/vram_uart_dumper.sv
// vram_uart_dumper: drains a contiguous range of DATA_W-bit words from
// data-memory port B and sends them byte by byte (byte 0 first, LSB first)
// on a UART 8N1 transmit line.
module vram_uart_dumper #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] q_b,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE, ADDR, CAPT, START_BIT, DATA_BITS, STOP_BIT, FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_reg_q, addr_reg_d;
    logic [ADDR_W-1:0]   address_b_q, address_b_d;
    logic [15:0]         words_left_q, words_left_d;
    logic [DATA_W-1:0]   word_buf_q, word_buf_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;
    logic [7:0]          cur_byte;
    logic [2:0]          bit_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    // The byte on the wire always sits in the low 8 bits of word_buf; the
    // buffer is shifted down one byte after each stop bit.
    assign bit_end  = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign cur_byte = word_buf_q[7:0];
    assign bit_nxt  = bit_idx_q + 3'd1;
    assign addr_nxt = addr_reg_q + ADDR_W'(1);

    // Next-state and next-output computation; outputs are decided one cycle
    // ahead so tx/busy/done/address_b come straight from flops.
    always_comb begin
        state_d      = state_q;
        addr_reg_d   = addr_reg_q;
        address_b_d  = address_b_q;
        words_left_d = words_left_q;
        word_buf_d   = word_buf_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = baud_cnt_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    addr_reg_d   = base_addr;
                    words_left_d = word_count;
                    if (word_count == 16'd0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = ADDR;
                        address_b_d = base_addr;
                        busy_d      = 1'b1;
                    end
                end
            end
            ADDR: state_d = CAPT;
            CAPT: begin
                word_buf_d = q_b;
                byte_idx_d = '0;
                baud_cnt_d = '0;
                tx_d       = 1'b0;
                state_d    = START_BIT;
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    tx_d       = cur_byte[0];
                    state_d    = DATA_BITS;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_nxt;
                        tx_d      = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q != BIDX_W'(NBYTES - 1)) begin
                        // Next byte of the same word: no idle gap.
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                        word_buf_d = word_buf_q >> 8;
                        tx_d       = 1'b0;
                        state_d    = START_BIT;
                    end else begin
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q != 16'd1) begin
                            addr_reg_d  = addr_nxt;
                            address_b_d = addr_nxt;
                            state_d     = ADDR;
                        end else begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any frame and forces the line idle high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_reg_q   <= '0;
            address_b_q  <= '0;
            words_left_q <= '0;
            word_buf_q   <= '0;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            baud_cnt_q   <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_reg_q   <= addr_reg_d;
            address_b_q  <= address_b_d;
            words_left_q <= words_left_d;
            word_buf_q   <= word_buf_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign address_b = address_b_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/vram_uart_dumper.md
Name: vram_uart_dumper

Overview:
Reads processed audio out of the vector data memory through its 128-bit port B and streams it to a host over a UART 8N1 transmit line. It is the read-out end of the path the processor writes: the processor writes FIR results into data memory, and this block drains a contiguous range of 128-bit words byte by byte. It sits beside the processor and shares data-memory port B, with wren_b held low by the integrator while this block is busy.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range 2 to 65535.
ADDR_W, 15, port-B word address width.
DATA_W, 128, port-B word width; must be a multiple of 8.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
base_addr  in  ADDR_W  first word address; captured on accepted start.
word_count  in  16  number of DATA_W words to send; captured on accepted start.
address_b  out  ADDR_W  port-B read address.
q_b  in  DATA_W  port-B read data; valid exactly 1 cycle after address_b is presented.
tx  out  1  UART serial output; idle high.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; tx=1, busy=0, done=0, address_b=0; all counters and the shift register cleared. Reset mid-frame aborts the dump with tx forced high immediately; no partial-frame completion.
- States: IDLE, ADDR, CAPT, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE: when start=1, capture base_addr into addr_reg and word_count into words_left. If word_count=0, go to FINISH; otherwise go to ADDR. start while not in IDLE is ignored.
- ADDR: address_b=addr_reg for one cycle, then go to CAPT.
- CAPT: latch q_b into a DATA_W word buffer, set byte_idx=0, then go to START_BIT. Total latency from start to tx falling edge is 3 cycles.
- Byte order: byte k = word[8k+7:8k], sent with k=0 first. Bit order is LSB first.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx < DATA_W/8-1: increment byte_idx and go to START_BIT. Back-to-back frames have no idle gap.
  - else decrement words_left. If the result is nonzero, increment addr_reg (wrapping modulo 2^ADDR_W, so 0x7FFF+1=0x0000) and go to ADDR. Otherwise go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, then return to IDLE. A start asserted in the FINISH cycle is ignored. A start in the following IDLE cycle is accepted.
- tx is registered (glitch-free) and equals 1 in IDLE, ADDR, CAPT and FINISH.
- address_b holds its last value outside ADDR.
- Baud counter reloads at every bit boundary; no drift is accumulated across frames.
- One word takes DATA_W/8*10*CLKS_PER_BIT + 2 cycles. With defaults that is 16*10*434 + 2 = 69442 cycles.

Test Plan:
1. CLKS_PER_BIT=4; base_addr=0x0010, word_count=1; memory[0x10]=0x0F0E..0100 (byte k = k) -> address_b=0x0010 in the 2nd cycle after start; tx falls on the 3rd cycle; 16 frames decode to 0x00,0x01..0x0F; done pulses once; busy low afterwards.
2. word_count=0 -> busy stays 0, tx stays 1, done pulses on the cycle after start.
3. base_addr=0x7FFF, word_count=2 -> address_b sequence is 0x7FFF then 0x0000; 32 bytes received in order.
4. start re-pulsed during byte 5 of a dump -> ignored: byte stream and done timing are identical to the single-start run.
5. reset driven low mid data bit of byte 3 -> tx=1 in the same cycle (asynchronous); busy=0; no done pulse; a fresh start after release dumps correctly from base_addr.
6. Bit-timing check with CLKS_PER_BIT=434 -> every tx level holds for exactly 434 cycles; stop bit is followed directly by the next start bit within a word.
